// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Optional fetch aging (anti-starvation) is built when MEM_ARB_AGE_EN is defined.
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int AGE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    output logic          if_stall,
    input  logic          d_re,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          d_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rdy
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } state_t;

    state_t state;
    state_t state_nx;
    logic   grant_f;
    logic   grant_d;
    logic   finish;
    logic   d_req;
    logic   f_req;
    logic   age_hit;

    if (AGE_MAX < 1) begin : g_bad_age
        $error("AGE_MAX must be at least 1");
    end

    // A requester whose done is high this cycle is still holding the old request
    assign d_req    = (d_re | d_we) & ~d_done;
    assign f_req    = if_req & ~if_done;
    assign if_stall = if_req & ~if_done;
    assign d_stall  = (d_re | d_we) & ~d_done;
    assign mem_en   = (state != IDLE);

`ifdef MEM_ARB_AGE_EN
    localparam int AGW = $clog2(AGE_MAX + 1);
    localparam logic [AGW-1:0] AGE_TOP = AGW'(AGE_MAX);

    logic [AGW-1:0] age;

    assign age_hit = (age == AGE_TOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age <= '0;
        end else if (grant_f) begin
            age <= '0;
        end else if (grant_d && if_req && !age_hit) begin
            age <= age + AGW'(1);
        end
    end
`else
    assign age_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        grant_f  = 1'b0;
        grant_d  = 1'b0;
        finish   = 1'b0;
        unique case (state)
            IDLE: begin
                if (age_hit && f_req) begin
                    grant_f  = 1'b1;
                    state_nx = FETCH;
                end else if (d_req) begin
                    grant_d  = 1'b1;
                    state_nx = DATA;
                end else if (f_req) begin
                    grant_f  = 1'b1;
                    state_nx = FETCH;
                end
            end
            FETCH, DATA: begin
                if (mem_rdy) begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            if_done <= finish && (state == FETCH);
            d_done  <= finish && (state == DATA);
            // Write wins if both strobes are raised together
            if (grant_d) begin
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_we    <= d_we;
            end else if (grant_f) begin
                mem_addr <= if_addr;
                mem_we   <= 1'b0;
            end
            if (finish && (state == FETCH)) begin
                if_rdata <= mem_rdata;
            end
            if (finish && (state == DATA) && !mem_we) begin
                d_rdata <= mem_rdata;
            end
        end
    end

    illegal_rw: assert property (
        @(posedge clk) disable iff (!rst) !(d_re && d_we)
    );

    one_done: assert property (
        @(posedge clk) disable iff (!rst) !(if_done && d_done)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a memory-ownership model
// checked every cycle, plus literal expectations per scenario.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        d_re;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rdy;

    int errors = 0;
    int checks = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .d_re      (d_re),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .d_stall   (d_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the memory, what was latched at grant, what is returned
    localparam int NONE = 0;
    localparam int OWNF = 1;
    localparam int OWND = 2;

    int          m_owner    = NONE;
    logic [15:0] m_addr     = '0;
    logic        m_we       = 1'b0;
    logic [15:0] m_wdata    = '0;
    logic        e_if_done  = 1'b0;
    logic        e_d_done   = 1'b0;
    logic [15:0] e_if_rdata = '0;
    logic [15:0] e_d_rdata  = '0;

    always @(posedge clk or negedge rst) begin
        logic nif;
        logic nd;
        if (!rst) begin
            m_owner    = NONE;
            m_addr     = '0;
            m_we       = 1'b0;
            m_wdata    = '0;
            e_if_done  = 1'b0;
            e_d_done   = 1'b0;
            e_if_rdata = '0;
            e_d_rdata  = '0;
        end else begin
            nif = 1'b0;
            nd  = 1'b0;
            if (m_owner != NONE) begin
                if (mem_rdy) begin
                    if (m_owner == OWNF) begin
                        e_if_rdata = mem_rdata;
                        nif = 1'b1;
                    end else begin
                        if (!m_we) e_d_rdata = mem_rdata;
                        nd = 1'b1;
                    end
                    m_owner = NONE;
                end
            end else if ((d_re || d_we) && !e_d_done) begin
                m_owner = OWND;
                m_addr  = d_addr;
                m_we    = d_we;
                m_wdata = d_wdata;
            end else if (if_req && !e_if_done) begin
                m_owner = OWNF;
                m_addr  = if_addr;
                m_we    = 1'b0;
            end
            e_if_done = nif;
            e_d_done  = nd;
        end
    end

    always @(negedge clk) begin
        chk("mem_en", mem_en, m_owner != NONE);
        chk("if_done", if_done, e_if_done);
        chk("d_done", d_done, e_d_done);
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        chk("if_stall", if_stall, if_req && !e_if_done);
        chk("d_stall", d_stall, (d_re || d_we) && !e_d_done);
        if (m_owner != NONE) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (!rst) begin
            chk("rst_addr", mem_addr, 16'h0);
            chk("rst_wdata", mem_wdata, 16'h0);
            chk("rst_we", mem_we, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Wait for the grant, hold off lag cycles, then a one-cycle mem_rdy
    task automatic serve(input int lag, input logic [15:0] data);
        for (int i = 0; i < 20 && mem_en !== 1'b1; i++) tick();
        chk("serve_grant", mem_en, 1'b1);
        repeat (lag) tick();
        mem_rdy   = 1'b1;
        mem_rdata = data;
        tick();
        mem_rdy   = 1'b0;
        mem_rdata = 16'h0;
    endtask

    initial begin
        rst       = 1'b0;
        if_req    = 1'b1;
        if_addr   = 16'h0010;
        d_re      = 1'b0;
        d_we      = 1'b0;
        d_addr    = 16'h0;
        d_wdata   = 16'h0;
        mem_rdata = 16'h0;
        mem_rdy   = 1'b1;
        repeat (3) tick();
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_if_done", if_done, 1'b0);
        chk("rst_d_done", d_done, 1'b0);

        rst     = 1'b1;
        mem_rdy = 1'b0;
        tick();
        chk("rel_mem_en", mem_en, 1'b1);
        chk("rel_addr", mem_addr, 16'h0010);
        serve(0, 16'h0F0F);
        chk("rel_if_done", if_done, 1'b1);
        if_req = 1'b0;
        tick();

        // single fetch
        if_addr = 16'h0040;
        if_req  = 1'b1;
        serve(2, 16'hB12C);
        chk("fetch_done", if_done, 1'b1);
        chk("fetch_rdata", if_rdata, 16'hB12C);
        chk("fetch_stall", if_stall, 1'b0);
        if_req = 1'b0;
        tick();
        chk("fetch_one_pulse", if_done, 1'b0);

        // contention: data first, one idle cycle, then fetch
        if_req  = 1'b1;
        if_addr = 16'h0042;
        d_re    = 1'b1;
        d_addr  = 16'h0100;
        tick();
        chk("cont_d_addr", mem_addr, 16'h0100);
        chk("cont_d_we", mem_we, 1'b0);
        serve(1, 16'hCAFE);
        chk("cont_d_done", d_done, 1'b1);
        chk("cont_d_rdata", d_rdata, 16'hCAFE);
        chk("cont_gap", mem_en, 1'b0);
        chk("cont_if_wait", if_done, 1'b0);
        d_re = 1'b0;
        tick();
        chk("cont_f_en", mem_en, 1'b1);
        chk("cont_f_addr", mem_addr, 16'h0042);
        serve(0, 16'h5A5A);
        chk("cont_f_done", if_done, 1'b1);
        chk("cont_f_rdata", if_rdata, 16'h5A5A);
        if_req = 1'b0;
        tick();

        // write with inputs changing after grant
        d_we    = 1'b1;
        d_addr  = 16'hFFFE;
        d_wdata = 16'h1234;
        tick();
        chk("wr_we", mem_we, 1'b1);
        chk("wr_addr", mem_addr, 16'hFFFE);
        chk("wr_wdata", mem_wdata, 16'h1234);
        d_addr  = 16'h0000;
        d_wdata = 16'hFFFF;
        serve(3, 16'hDEAD);
        chk("wr_done", d_done, 1'b1);
        chk("wr_d_rdata", d_rdata, 16'hCAFE);
        chk("wr_if_rdata", if_rdata, 16'h5A5A);
        d_we = 1'b0;
        tick();

        // fetch flushed after grant still completes
        if_req  = 1'b1;
        if_addr = 16'h0300;
        tick();
        if_req = 1'b0;
        serve(1, 16'h7777);
        chk("flush_done", if_done, 1'b1);
        chk("flush_rdata", if_rdata, 16'h7777);
        tick();

        // mem_rdy while idle
        mem_rdy   = 1'b1;
        mem_rdata = 16'h9999;
        repeat (2) tick();
        mem_rdy = 1'b0;
        chk("idle_rdy_if", if_done, 1'b0);
        chk("idle_rdy_d", d_done, 1'b0);
        tick();

        // reset mid-access, then a late mem_rdy
        d_re   = 1'b1;
        d_addr = 16'h0200;
        tick();
        chk("mid_en", mem_en, 1'b1);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_en", mem_en, 1'b0);
        @(posedge clk);
        #2;
        d_re = 1'b0;
        tick();
        rst     = 1'b1;
        mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0;
        chk("late_rdy_done", d_done, 1'b0);
        chk("late_rdy_en", mem_en, 1'b0);
        tick();
        chk("late_rdy_done2", d_done, 1'b0);
        chk("late_d_rdata", d_rdata, 16'h0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
